vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Owns the single-port pixel memory behind the VGA timing generator and shares it between two requesters.
- Requester 1 is display scanout: reads addressed by col/row while disp_ena is high.
- Requester 2 is a host writer with a valid/ready handshake, buffered in a small FIFO.
- Scanout always has absolute priority. Host writes drain only in blanking, after a one-cycle bus turnaround.

Parameters:
- H_PIXELS, 500, active pixels per line (col range 0..H_PIXELS-1)
- V_PIXELS, 250, active lines per frame (row range 0..V_PIXELS-1)
- ADDR_W, 17, memory address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS
- DATA_W, 8, pixel width
- FIFO_DEPTH, 4, host write FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- disp_ena  in  1  active-video indicator from timing generator
- col  in  10  current column from timing generator
- row  in  9  current row from timing generator
- wr_valid  in  1  host write request
- wr_ready  out  1  FIFO can accept; transfer when wr_valid & wr_ready
- wr_addr  in  ADDR_W  host write address
- wr_data  in  DATA_W  host write data
- mem_addr  out  ADDR_W  memory address (combinational from state/inputs)
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, valid the cycle after the address
- pixel_data  out  DATA_W  scanout pixel (registered)
- pixel_valid  out  1  pixel_data qualifier (registered)
- err_oob  out  1  sticky: a host write with wr_addr >= H_PIXELS*V_PIXELS was discarded
- fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (async, any time, including mid-write): FSM = IDLE; FIFO emptied; wr_ready=1 on the first cycle after release; pixel_valid=0; pixel_data=0; err_oob=0; fifo_level=0; mem_we=0; mem_addr=0; mem_wdata=0.
- FSM states and transitions:
  - IDLE: disp_ena=1 -> SCAN; else FIFO non-empty -> WRITE; else stay.
  - SCAN: disp_ena=0 -> TURN; else stay.
  - TURN: exactly one cycle, no memory access. disp_ena=1 -> SCAN; else FIFO non-empty -> WRITE; else IDLE.
  - WRITE: disp_ena=1 -> SCAN, with no turnaround; else FIFO empty after this pop -> IDLE; else stay.
- Scan access: any cycle t with disp_ena=1 (regardless of the prior state) drives mem_we=0 and mem_addr=row*H_PIXELS+col, truncated to ADDR_W.
  - mem_rdata is registered at the end of t+1.
  - pixel_data/pixel_valid=1 appear in cycle t+2, so latency is 2 cycles.
  - pixel_valid is disp_ena delayed 2 cycles.
- Write access: in a WRITE-state cycle with disp_ena=0 and FIFO non-empty:
  - pop the head entry; mem_we=1; mem_addr/mem_wdata come from that entry.
  - One write per cycle, back-to-back.
  - disp_ena=1 in WRITE preempts: no pop that cycle, and the head entry stays queued.
- No write is ever issued in SCAN, TURN or IDLE, or in any cycle with disp_ena=1.
- FIFO:
  - wr_ready = (fifo_level < FIFO_DEPTH), computed from registered level.
  - Push and pop in the same cycle are allowed; level is unchanged.
  - When full, wr_ready=0, so no push is possible even if a pop occurs that cycle.
  - FIFO order is preserved.
- Out-of-range host write: an accepted transfer with wr_addr >= H_PIXELS*V_PIXELS:
  - handshake completes (counts as accepted);
  - not pushed;
  - err_oob set the next cycle and held until rst.
- fifo_level is the registered occupancy.

Test Plan:
- Reset release, disp_ena=1 with col=3, row=2 at cycle t -> mem_addr=1003, mem_we=0 at t; memory returns 0x5A at t+1 -> pixel_data=0x5A, pixel_valid=1 at t+2.
- 3 host writes (addr 10/11/12, data 1/2/3) pushed during active video -> no mem_we while disp_ena=1; fifo_level=3. disp_ena falls at cycle b -> TURN at b, writes at b+1, b+2, b+3 in order; IDLE at b+4.
- Push 5 writes while disp_ena=1 -> wr_ready=0 after the 4th; 5th held until the first blanking pop; fifo_level never exceeds 4.
- WRITE with 2 entries queued, disp_ena rises -> that cycle is a scan read (mem_we=0); both entries retained; after the next TURN they are written in order.
- Write to wr_addr=125000 -> wr_ready handshake completes; err_oob=1 the next cycle; fifo_level unchanged; no mem_we for it.
- Assert rst while 2 entries are queued in WRITE -> fifo_level=0, mem_we=0, and pixel_valid=0 immediately (async); after release the dropped entries are never written.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Pixel memory arbiter: display scanout reads take priority and host writes
// are queued in a FIFO and drained during blanking after a turnaround cycle.
module vga_fb_arbiter #(
    parameter int H_PIXELS   = 500,
    parameter int V_PIXELS   = 250,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_ena,
    input  logic [9:0]        col,
    input  logic [8:0]        row,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid,
    output logic              err_oob,
    output logic [2:0]        fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NPIX = H_PIXELS * V_PIXELS;
    localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, TURN, WRITE} state_t;

    state_t st, cur;

    logic [ADDR_W-1:0] fa [FIFO_DEPTH];
    logic [DATA_W-1:0] fd [FIFO_DEPTH];
    logic [PW-1:0]     rp, wp;
    logic [2:0]        lvl;
    logic              empty, accept, oob, push, pop;
    logic              disp_d;
    logic [ADDR_W-1:0] scan_addr;

    assign empty     = (lvl == 3'd0);
    assign wr_ready  = (lvl < DEPTH_L);
    assign accept    = wr_valid & wr_ready;
    assign oob       = (32'(wr_addr) >= NPIX);
    assign push      = accept & ~oob;
    assign pop       = (cur == WRITE);
    assign scan_addr = ADDR_W'(row) * ADDR_W'(H_PIXELS) + ADDR_W'(col);

    // State in effect for the current cycle; st holds the previous cycle's.
    always_comb begin
        cur = IDLE;
        unique case (st)
            SCAN: begin
                cur = disp_ena ? SCAN : TURN;
            end
            IDLE, TURN, WRITE: begin
                if (disp_ena)
                    cur = SCAN;
                else if (!empty)
                    cur = WRITE;
                else
                    cur = IDLE;
            end
            default: cur = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (disp_ena) begin
                mem_addr = scan_addr;
            end else if (cur == WRITE) begin
                mem_we    = 1'b1;
                mem_addr  = fa[rp];
                mem_wdata = fd[rp];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fa[wp] <= wr_addr;
            fd[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            rp          <= '0;
            wp          <= '0;
            lvl         <= 3'd0;
            err_oob     <= 1'b0;
            disp_d      <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
        end else begin
            st <= cur;
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            unique case ({push, pop})
                2'b10:   lvl <= lvl + 3'd1;
                2'b01:   lvl <= lvl - 3'd1;
                default: lvl <= lvl;
            endcase
            if (accept && oob)
                err_oob <= 1'b1;
            disp_d      <= disp_ena;
            pixel_valid <= disp_d;
            if (disp_d)
                pixel_data <= mem_rdata;
        end
    end

    assign fifo_level = lvl;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: queue-based model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_vga_fb_arbiter;

    localparam int H = 500;
    localparam int V = 250;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_ena = 1'b0;
    logic [9:0]  col = '0;
    logic [8:0]  row = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [16:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        err_oob;
    logic [2:0]  fifo_level;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .disp_ena(disp_ena), .col(col), .row(row),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .err_oob(err_oob), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mval(input logic [16:0] a);
        return a[7:0] ^ 8'hB1;
    endfunction

    // Synchronous-read memory stand-in
    always @(posedge clk) mem_rdata <= mval(mem_addr);

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [16:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t        q[$];
    bit          prev_disp, merr, pv1, pv2, m_wr, m_rdy;
    logic [7:0]  pd1, pd2;
    int          sa;
    logic [16:0] ea;

    // Model: a write happens only when neither this nor the previous cycle
    // was active video and something is queued.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_disp = 0;
            merr = 0;
            pv1 = 0;
            pv2 = 0;
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_pv", pixel_valid, 0);
            chk("rst_pd", pixel_data, 0);
            chk("rst_lvl", fifo_level, 0);
            chk("rst_err", err_oob, 0);
        end else begin
            sa = row * H + col;
            ea = sa[16:0];
            m_wr = !disp_ena && !prev_disp && q.size() > 0;
            m_rdy = q.size() < 4;
            chk("wr_ready", wr_ready, int'(m_rdy));
            chk("fifo_level", fifo_level, q.size());
            chk("err_oob", err_oob, int'(merr));
            chk("pixel_valid", pixel_valid, int'(pv2));
            if (pv2)
                chk("pixel_data", pixel_data, pd2);
            chk("mem_we", mem_we, int'(m_wr));
            if (disp_ena)
                chk("scan_addr", mem_addr, ea);
            if (m_wr && mem_we) begin
                chk("wr_addr", mem_addr, q[0].a);
                chk("wr_data", mem_wdata, q[0].d);
            end
            pv2 = pv1;
            pd2 = pd1;
            pv1 = disp_ena;
            pd1 = mval(ea);
            if (m_wr)
                void'(q.pop_front());
            if (wr_valid && m_rdy) begin
                if (int'(wr_addr) >= H * V)
                    merr = 1;
                else
                    q.push_back('{wr_addr, wr_data});
            end
            prev_disp = disp_ena;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [16:0] a, input logic [7:0] d);
        bit done;
        done = 0;
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = wr_ready;
            step();
        end
        if (!done)
            chk("send_timeout", 0, 1);
        wr_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Scan latency and address truncation
        disp_ena = 1'b1; col = 10'd3; row = 9'd2;
        @(negedge clk);
        chk("t1_addr", mem_addr, 1003);
        chk("t1_we", mem_we, 0);
        step();
        row = 9'd300; col = 10'd1000;
        @(negedge clk);
        chk("t1_trunc", mem_addr, 19928);
        step();
        disp_ena = 1'b0;
        @(negedge clk);
        chk("t1_pix", pixel_data, 8'h5A);
        chk("t1_pv", pixel_valid, 1);
        step();
        step();

        // Writes queued during active video drain after turnaround
        disp_ena = 1'b1; col = 10'd10; row = 9'd5;
        for (int i = 0; i < 3; i++)
            send(17'(10 + i), 8'(1 + i));
        @(negedge clk);
        chk("t2_lvl", fifo_level, 3);
        chk("t2_we", mem_we, 0);
        step();
        disp_ena = 1'b0;
        @(negedge clk);
        chk("t2_turn_we", mem_we, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("t2_we_on", mem_we, 1);
            chk("t2_addr", mem_addr, 10 + i);
            chk("t2_data", mem_wdata, 1 + i);
        end
        step();
        @(negedge clk);
        chk("t2_idle_we", mem_we, 0);
        chk("t2_idle_lvl", fifo_level, 0);
        step();

        // FIFO full backpressure, boundary scan address
        disp_ena = 1'b1; row = 9'd249; col = 10'd499;
        for (int i = 0; i < 4; i++)
            send(17'(20 + i), 8'(8'h20 + i));
        wr_valid = 1'b1; wr_addr = 17'd24; wr_data = 8'h24;
        @(negedge clk);
        chk("t3_full_rdy", wr_ready, 0);
        chk("t3_full_lvl", fifo_level, 4);
        chk("t3_edge_addr", mem_addr, 124999);
        step();
        step();
        disp_ena = 1'b0;
        send(17'd24, 8'h24);
        repeat (6) step();
        @(negedge clk);
        chk("t3_drained", fifo_level, 0);
        step();

        // Scan preempts WRITE; queued entries survive
        disp_ena = 1'b1; col = 10'd0; row = 9'd0;
        for (int i = 0; i < 3; i++)
            send(17'(30 + i), 8'(8'h30 + i));
        disp_ena = 1'b0;
        step();
        @(negedge clk);
        chk("t4_first", mem_addr, 30);
        step();
        disp_ena = 1'b1;
        @(negedge clk);
        chk("t4_pre_we", mem_we, 0);
        chk("t4_pre_lvl", fifo_level, 2);
        step();
        disp_ena = 1'b0;
        @(negedge clk);
        chk("t4_turn_we", mem_we, 0);
        step();
        @(negedge clk);
        chk("t4_second", mem_addr, 31);
        step();
        @(negedge clk);
        chk("t4_third", mem_addr, 32);
        step();

        // Out-of-range write sets sticky error, in-range edge is written
        send(17'd125000, 8'h77);
        @(negedge clk);
        chk("t5_err", err_oob, 1);
        chk("t5_lvl", fifo_level, 0);
        chk("t5_we", mem_we, 0);
        send(17'd124999, 8'h66);
        @(negedge clk);
        chk("t5_edge_we", mem_we, 1);
        chk("t5_edge_addr", mem_addr, 124999);
        chk("t5_err_hold", err_oob, 1);
        step();

        // Async reset mid-write drops queued entries
        disp_ena = 1'b1;
        for (int i = 0; i < 3; i++)
            send(17'(40 + i), 8'(8'h40 + i));
        disp_ena = 1'b0;
        step();
        chk("t6_pre_we", mem_we, 1);
        chk("t6_pre_pv", pixel_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_lvl", fifo_level, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_pv", pixel_valid, 0);
        chk("t6_err", err_oob, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rdy", wr_ready, 1);
        repeat (8) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
